rv_exec_core: RTL and testbench
===============================

Name: rv_exec_core

Overview:
- Parametrised multi-cycle RV32I integer execute core, successor to the single-instruction ALU core.
- Accepts one instruction per valid/ready handshake and runs FETCH-latch, DECODE, EXEC, WB.
- Supports all R-type ALU ops and all OP-IMM I-type ops.
- Owns an architectural register file and reports each result, destination and illegal status to the surrounding fetch/test logic.

Parameters:
- XLEN, 32, datapath width; only 32 is legal, and shift amount uses the low 5 bits.
- NREGS, 32, register count; 32 for RV32I, 16 for RV32E.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instr holds a valid instruction.
- instr  in  32  instruction word.
- instr_ready  out  1  core can accept an instruction; high only in IDLE.
- result_valid  out  1  one-cycle pulse in WB.
- result  out  XLEN  ALU result of the retiring instruction; 0 if illegal.
- result_rd  out  5  rd field of the retiring instruction.
- illegal  out  1  one-cycle pulse in WB when the instruction is not supported.
- retired  out  CNT_W  count of legally retired instructions; wraps at 2^CNT_W.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - State=IDLE; instr_ready=1; result_valid=0, illegal=0, result=0, result_rd=0, retired=0.
  - All registers cleared to 0.
- FSM IDLE -> DECODE -> EXEC -> WB -> IDLE:
  - IDLE: instr_ready=1. On instr_valid&instr_ready, latch instr and go to DECODE.
  - DECODE: read rs1/rs2 and sign-extend imm=instr[31:20] to XLEN. Latch op1=x[rs1], and op2=x[rs2] (R-type) or imm (I-type). Decode the ALU op and the illegal flag.
  - EXEC: compute the ALU result and register it.
  - WB: drive result_valid=1, result, result_rd and illegal. At the WB->IDLE edge, write x[rd] if legal and rd!=0, and increment retired if legal.
- Timing: handshake at edge T0; result_valid high during cycle T3. Next accept is possible at edge T4, so peak throughput is 1 instruction per 4 cycles.
- Ops:
  - ADD/ADDI, SUB: modulo 2^XLEN.
  - SLT/SLTI: signed compare; SLTU/SLTIU: unsigned compare (SLTIU compares against the sign-extended imm).
  - XOR, OR, AND and their immediate forms.
  - SLL/SLLI, SRL/SRLI: logical shifts. SRA/SRAI: arithmetic shift, sign-filling.
  - Shift amount = op2[4:0].
- Legality:
  - opcode 0110011 with funct7 0000000, or 0100000 only for funct3 000/101.
  - opcode 0010011 with any funct3. SLLI requires funct7=0000000; SRLI/SRAI require funct7 0000000/0100000.
  - If NREGS=16, any rs1/rs2/rd index >=16 is illegal.
  - Everything else is illegal: no write, no retire increment, result=0, illegal=1 for one cycle.
- Register file:
  - x0 reads 0 always; a write to x0 is discarded, but result still shows the computed value.
  - The write in WB is visible to an instruction accepted at edge T4, so no forwarding is needed.
- instr_valid while busy is ignored (instr_ready=0); instr is not sampled.
- reset_n asserted mid-operation aborts the instruction: no write, no pulse, FSM to IDLE.

Optional Feature:
- Macro: RV_EXEC_MUL_EN.
- When defined: opcode 0110011, funct7 0000001, funct3 000 is legal MUL. Result = low XLEN bits of op1*op2, single-cycle in EXEC, same latency.
- When undefined: that encoding is illegal like any other unsupported op.

Decomposition:
- Package rv_exec_pkg holds:
  - Opcode constants OPC_OP=0110011 and OPC_OPIMM=0010011.
  - Funct7 constants F7_BASE, F7_ALT and F7_MULDIV.
  - Funct3 constants.
  - alu_op_t enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL.
  - state_t enum: IDLE, DECODE, EXEC, WB.
- One sub-module, rv_regfile, parametrised by NREGS: 2 combinational read ports, 1 synchronous write port with enable, x0 hardwired to 0, async clear on reset_n.

Test Plan:
- Load and add, each run through a full handshake:
  - 0x00500093 (ADDI x1,x0,5) -> result=5, result_rd=1.
  - 0xFFD00113 (ADDI x2,x0,-3) -> result=0xFFFFFFFD.
  - 0x002081B3 (ADD x3,x1,x2) -> result=2, retired=3.
  - result_valid rises exactly 3 cycles after each accept edge.
- Signed vs unsigned, with x1=5, x2=-3:
  - SLT x4,x2,x1 -> 1; SLTU x5,x2,x1 -> 0.
  - SRA x6,x2,x1 -> 0xFFFFFFFF; SRL x7,x2,x1 -> 0x07FFFFFF.
  - SLLI x8,x1,31 -> 0x80000000.
- x0 and illegal:
  - ADDI x0,x0,7 -> result=7, subsequent read of x0 = 0.
  - 0x0000007F -> illegal=1, result=0, retired unchanged, no register changes.
  - SLLI with funct7=0100000 -> illegal.
- Handshake:
  - Hold instr_valid high continuously with changing instr -> only words present at IDLE accept edges execute; instr_ready low for 3 cycles after each accept.
- Reset mid-operation:
  - Assert reset_n low during EXEC of ADDI x9,x0,1 -> no result_valid, x9=0, retired=0, instr_ready=1 immediately.
- With RV_EXEC_MUL_EN and x1=5, x2=-3:
  - MUL x10,x1,x2 -> 0xFFFFFFF1.
  - Same word without the macro -> illegal=1.

Source files
------------

// File: rtl/rv_exec_pkg.sv
// Shared types, encodings and instruction decode for the rv_exec_core execute slice.
// The MUL encoding is only decoded as legal when RV_EXEC_MUL_EN is defined.
package rv_exec_pkg;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE, DECODE, EXEC, WB
    } state_t;

    typedef struct packed {
        alu_op_t op;
        logic    ill;
        logic    use_imm;
    } dec_t;

    // Map opcode/funct fields to an ALU op; anything unrecognised is flagged illegal.
    function automatic dec_t decode(input logic [6:0] opc, input logic [2:0] f3,
                                    input logic [6:0] f7);
        dec_t d;
        d.op      = ALU_ADD;
        d.ill     = 1'b1;
        d.use_imm = 1'b0;
        if (opc == OPC_OP) begin
            if (f7 == F7_BASE) begin
                d.ill = 1'b0;
                case (f3)
                    F3_ADD:  d.op = ALU_ADD;
                    F3_SLL:  d.op = ALU_SLL;
                    F3_SLT:  d.op = ALU_SLT;
                    F3_SLTU: d.op = ALU_SLTU;
                    F3_XOR:  d.op = ALU_XOR;
                    F3_SR:   d.op = ALU_SRL;
                    F3_OR:   d.op = ALU_OR;
                    default: d.op = ALU_AND;
                endcase
            end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                d.ill = 1'b0;
                d.op  = ALU_SUB;
            end else if (f7 == F7_ALT && f3 == F3_SR) begin
                d.ill = 1'b0;
                d.op  = ALU_SRA;
            end
`ifdef RV_EXEC_MUL_EN
            else if (f7 == F7_MULDIV && f3 == F3_ADD) begin
                d.ill = 1'b0;
                d.op  = ALU_MUL;
            end
`endif
        end else if (opc == OPC_OPIMM) begin
            d.use_imm = 1'b1;
            d.ill     = 1'b0;
            case (f3)
                F3_ADD:  d.op = ALU_ADD;
                F3_SLL:  begin d.op = ALU_SLL; d.ill = (f7 != F7_BASE); end
                F3_SLT:  d.op = ALU_SLT;
                F3_SLTU: d.op = ALU_SLTU;
                F3_XOR:  d.op = ALU_XOR;
                F3_SR:   begin
                    d.op  = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    d.ill = !(f7 == F7_BASE || f7 == F7_ALT);
                end
                F3_OR:   d.op = ALU_OR;
                default: d.op = ALU_AND;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// Architectural register file: two combinational read ports, one synchronous write port.
// x0 reads as zero and ignores writes; indices at or above NREGS read as zero.
module rv_regfile #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    localparam int unsigned IDX_W = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];

    assign rdata1 = (raddr1 == 5'd0 || 32'(raddr1) >= NREGS) ? '0 : regs[raddr1[IDX_W-1:0]];
    assign rdata2 = (raddr2 == 5'd0 || 32'(raddr2) >= NREGS) ? '0 : regs[raddr2[IDX_W-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0 && 32'(waddr) < NREGS) begin
            regs[waddr[IDX_W-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/rv_exec_core.sv
// Multi-cycle RV32I integer execute core: IDLE -> DECODE -> EXEC -> WB, one instruction per 4 cycles.
// Optional RV_EXEC_MUL_EN macro enables the single-cycle MUL encoding.
module rv_exec_core
    import rv_exec_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic             result_valid,
    output logic [XLEN-1:0]  result,
    output logic [4:0]       result_rd,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t          state, state_nxt;
    logic            accept, wr_en;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] op1_q, op2_q, rs1_data, rs2_data, imm_ext;
    alu_op_t         op_q;
    logic            ill_q;
    logic [4:0]      rd_q;
    dec_t            dec;
    logic            reg_bad;

    assign dec     = decode(instr_q[6:0], instr_q[14:12], instr_q[31:25]);
    assign imm_ext = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
    assign reg_bad = (32'(instr_q[19:15]) >= NREGS) || (32'(instr_q[11:7]) >= NREGS) ||
                     (!dec.use_imm && 32'(instr_q[24:20]) >= NREGS);

    function automatic logic [XLEN-1:0] alu(input alu_op_t op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return XLEN'($signed(a) < $signed(b));
            ALU_SLTU: return XLEN'(a < b);
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return XLEN'($signed(a) >>> sh);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
`ifdef RV_EXEC_MUL_EN
            ALU_MUL:  return a * b;
`endif
            default:  return '0;
        endcase
    endfunction

    rv_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .raddr1  (instr_q[19:15]),
        .raddr2  (instr_q[24:20]),
        .rdata1  (rs1_data),
        .rdata2  (rs2_data),
        .we      (wr_en),
        .waddr   (rd_q),
        .wdata   (result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state plus the handshake and register-write strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    accept    = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: state_nxt = EXEC;
            EXEC:   state_nxt = WB;
            WB: begin
                state_nxt = IDLE;
                wr_en     = !ill_q && rd_q != 5'd0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs; result doubles as the write-back data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q      <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            op_q         <= ALU_ADD;
            ill_q        <= 1'b0;
            rd_q         <= '0;
            instr_ready  <= 1'b1;
            result_valid <= 1'b0;
            result       <= '0;
            result_rd    <= '0;
            illegal      <= 1'b0;
            retired      <= '0;
        end else begin
            instr_ready  <= (state_nxt == IDLE);
            result_valid <= (state_nxt == WB);
            illegal      <= (state_nxt == WB) && ill_q;
            if (accept) instr_q <= instr;
            if (state == DECODE) begin
                op1_q <= rs1_data;
                op2_q <= dec.use_imm ? imm_ext : rs2_data;
                op_q  <= dec.op;
                ill_q <= dec.ill || reg_bad;
                rd_q  <= instr_q[11:7];
            end
            if (state == EXEC) begin
                result    <= ill_q ? '0 : alu(op_q, op1_q, op2_q);
                result_rd <= rd_q;
            end
            if (state == WB && !ill_q) retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rv_exec_core.sv
// Directed self-checking bench for rv_exec_core (honours RV_EXEC_MUL_EN when defined).
module tb_rv_exec_core;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  result_rd;
    logic        illegal;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_exec_core #(.XLEN(32), .NREGS(32), .CNT_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .result_valid (result_valid),
        .result       (result),
        .result_rd    (result_rd),
        .illegal      (illegal),
        .retired      (retired)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full handshake; checks accept readiness, 3-cycle latency, WB payload and pulse width.
    task automatic run(input string tag, input logic [31:0] w, input logic [31:0] exp_res,
                       input logic [4:0] exp_rd, input logic exp_ill);
        int cyc;
        bit seen;
        @(negedge clk);
        check({tag, "_ready"}, 32'(instr_ready), 32'd1);
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 8) begin
            @(negedge clk);
            cyc++;
            instr_valid = 1'b0;
            if (result_valid) seen = 1;
        end
        check({tag, "_lat"}, 32'(cyc), 32'd3);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_rd"}, 32'(result_rd), 32'(exp_rd));
        check({tag, "_ill"}, 32'(illegal), 32'(exp_ill));
        @(negedge clk);
        check({tag, "_pulse"}, {30'd0, result_valid, illegal}, 32'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_rv", 32'(result_valid), 32'd0);
        check("rst_ill", 32'(illegal), 32'd0);
        check("rst_res", result, 32'd0);
        check("rst_rd", 32'(result_rd), 32'd0);
        check("rst_ret", retired, 32'd0);
        reset_n = 1'b1;

        // Load and add
        run("addi_x1", 32'h00500093, 32'h00000005, 5'd1, 1'b0);
        run("addi_x2", 32'hFFD00113, 32'hFFFFFFFD, 5'd2, 1'b0);
        run("add_x3",  32'h002081B3, 32'h00000002, 5'd3, 1'b0);
        check("ret_3", retired, 32'd3);

        // Signed vs unsigned, shifts
        run("slt",  32'h00112233, 32'h00000001, 5'd4, 1'b0);
        run("sltu", 32'h001132B3, 32'h00000000, 5'd5, 1'b0);
        run("sra",  32'h40115333, 32'hFFFFFFFF, 5'd6, 1'b0);
        run("srl",  32'h001153B3, 32'h07FFFFFF, 5'd7, 1'b0);
        run("slli", 32'h01F09413, 32'h80000000, 5'd8, 1'b0);

        // x0 write discarded but reported
        run("addi_x0", 32'h00700013, 32'h00000007, 5'd0, 1'b0);
        run("read_x0", 32'h00000593, 32'h00000000, 5'd11, 1'b0);
        check("ret_10", retired, 32'd10);

        // Illegal encodings
        run("bad_opc",  32'h0000007F, 32'h00000000, 5'd0, 1'b1);
        run("bad_slli", 32'h40109713, 32'h00000000, 5'd14, 1'b1);
        check("ret_ill", retired, 32'd10);
        run("read_x1",  32'h00008693, 32'h00000005, 5'd13, 1'b0);
        run("read_x14", 32'h00070793, 32'h00000000, 5'd15, 1'b0);

        // instr_valid held high with changing words; only IDLE-edge words execute
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 32'h01100813;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("hs_ready", 32'(instr_ready), (k == 4) ? 32'd1 : 32'd0);
            if (k == 3) begin
                check("hs_rv1", 32'(result_valid), 32'd1);
                check("hs_res1", result, 32'd17);
                check("hs_rd1", 32'(result_rd), 32'd16);
            end
            if (k == 7) begin
                check("hs_rv2", 32'(result_valid), 32'd1);
                check("hs_res2", result, 32'd18);
                check("hs_rd2", 32'(result_rd), 32'd17);
            end
            instr = (k == 4) ? 32'h00180893 : 32'h06300813;
        end
        @(negedge clk);
        instr_valid = 1'b0;
        check("hs_ret", retired, 32'd14);

        // Reset during EXEC aborts ADDI x9,x0,1
        @(negedge clk);
        instr       = 32'h00100493;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_ready", 32'(instr_ready), 32'd1);
        check("mid_rv", 32'(result_valid), 32'd0);
        check("mid_ret", retired, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("mid_hold_rv", 32'(result_valid), 32'd0);
        end
        reset_n = 1'b1;
        run("read_x9", 32'h00048613, 32'h00000000, 5'd12, 1'b0);
        check("mid_ret1", retired, 32'd1);

        // MUL: legal only with the optional feature
        run("re_x1", 32'h00500093, 32'h00000005, 5'd1, 1'b0);
        run("re_x2", 32'hFFD00113, 32'hFFFFFFFD, 5'd2, 1'b0);
`ifdef RV_EXEC_MUL_EN
        run("mul", 32'h02208533, 32'hFFFFFFF1, 5'd10, 1'b0);
        check("mul_ret", retired, 32'd4);
`else
        run("mul_off", 32'h02208533, 32'h00000000, 5'd10, 1'b1);
        check("mul_ret", retired, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
